// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the loader.
// master = loader side, slave = stream source / instruction memory side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  out_ready;
    logic                  out_ctrl_memwrt;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [31:0]           out_data;

    modport master (
        input  in_data, in_valid,
        output out_ready, out_ctrl_memwrt, out_addr, out_data
    );

    modport slave (
        output in_data, in_valid,
        input  out_ready, out_ctrl_memwrt, out_addr, out_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: parses a 16-bit word count then big-endian 32-bit words into imem.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte (CHECK/ERROR path).
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_ctrl_start,
    imem_loader_if.master bus,
    output logic          out_ctrl_cpuhold,
    output logic          out_done,
    output logic          out_error
);
    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        LOAD,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } state_t;

    state_t                state, state_nxt;
    logic                  acc, ld_acc, word_done;
    logic [7:0]            cnt_hi;
    logic [15:0]           words_left;
    logic [1:0]            lane;
    logic [23:0]           shreg;
    logic [ADDR_WIDTH-1:0] addr_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum;
    localparam state_t FIN_STATE = CHECK;
`else
    localparam state_t FIN_STATE = DONE;
`endif

    // out_ready is a registered decode of the state, so it tracks state exactly
    assign acc       = bus.in_valid && bus.out_ready;
    assign ld_acc    = acc && (state == LOAD) && (words_left != 16'd0);
    assign word_done = ld_acc && (lane == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_ctrl_start) state_nxt = CNT_HI;
            CNT_HI: if (acc) state_nxt = CNT_LO;
            CNT_LO: if (acc) state_nxt = ({cnt_hi, bus.in_data} == 16'd0) ? FIN_STATE : LOAD;
`ifdef LOADER_CHECKSUM_EN
            LOAD:   if (word_done && words_left == 16'd1) state_nxt = CHECK;
            CHECK:  if (acc) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
`else
            // leave once the final word's strobe has been presented
            LOAD:   if (bus.out_ctrl_memwrt && words_left == 16'd0) state_nxt = DONE;
`endif
            DONE, ERROR: if (in_ctrl_start) state_nxt = CNT_HI;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_ready       <= 1'b0;
            bus.out_ctrl_memwrt <= 1'b0;
            bus.out_addr        <= '0;
            bus.out_data        <= '0;
            out_ctrl_cpuhold    <= 1'b1;
            out_done            <= 1'b0;
            out_error           <= 1'b0;
            cnt_hi              <= '0;
            words_left          <= '0;
            lane                <= '0;
            shreg               <= '0;
            addr_cnt            <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum                <= '0;
`endif
        end else begin
            bus.out_ctrl_memwrt <= 1'b0;
            bus.out_ready       <= (state_nxt == CNT_HI) || (state_nxt == CNT_LO) ||
`ifdef LOADER_CHECKSUM_EN
                                   (state_nxt == CHECK) ||
`endif
                                   (state_nxt == LOAD);
            out_done            <= (state_nxt == DONE);
            out_ctrl_cpuhold    <= (state_nxt != DONE);
`ifdef LOADER_CHECKSUM_EN
            out_error           <= (state_nxt == ERROR);
`else
            out_error           <= 1'b0;
`endif
            if (state != CNT_HI && state_nxt == CNT_HI) begin
                addr_cnt <= '0;
                lane     <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (acc && state == CNT_HI) cnt_hi <= bus.in_data;
            if (acc && state == CNT_LO) words_left <= {cnt_hi, bus.in_data};
            if (ld_acc) begin
                shreg <= {shreg[15:0], bus.in_data};
                lane  <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum  <= csum ^ bus.in_data;
`endif
            end
            // address wraps naturally at the memory depth
            if (word_done) begin
                bus.out_ctrl_memwrt <= 1'b1;
                bus.out_data        <= {shreg, bus.in_data};
                bus.out_addr        <= addr_cnt;
                addr_cnt            <= addr_cnt + ADDR_WIDTH'(1);
                words_left          <= words_left - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads against a queue scoreboard of expected imem writes.
module tb_imem_loader;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_ctrl_start = 1'b0;
  logic out_ctrl_cpuhold, out_done, out_error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .in_ctrl_start(in_ctrl_start),
    .bus(bus),
    .out_ctrl_cpuhold(out_ctrl_cpuhold),
    .out_done(out_done),
    .out_error(out_error)
  );

  exp_t        exp_q[$];
  logic [31:0] wbuf[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: every write strobe must match the oldest expected write, in the expected cycle
  always @(negedge clk) begin
    if (bus.out_ctrl_memwrt) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL wr_unexpected: strobe at addr %h data %h, none expected", bus.out_addr, bus.out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.out_addr), 32'(e.addr));
        chk("wr_data", bus.out_data, e.data);
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the byte is accepted
  task automatic put(input logic [7:0] b, input bit gaps, input bit push,
                     input logic [31:0] wd, input int idx);
    int t = 0;
    exp_t e;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.out_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_ready) begin
      n_chk++;
      $display("FAIL ready_timeout: out_ready=0 expected 1");
    end else if (push) begin
      e.addr = AW'(idx % DEPTH);
      e.data = wd;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    in_ctrl_start = 1'b1;
    @(negedge clk);
    in_ctrl_start = 1'b0;
    chk("start_ready", 32'(bus.out_ready), 32'd1);
    chk("start_done", 32'(out_done), 32'd0);
    chk("start_error", 32'(out_error), 32'd0);
    chk("start_hold", 32'(out_ctrl_cpuhold), 32'd1);
  endtask

  task automatic check_reset();
    chk("rst_ready", 32'(bus.out_ready), 32'd0);
    chk("rst_memwrt", 32'(bus.out_ctrl_memwrt), 32'd0);
    chk("rst_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_hold", 32'(out_ctrl_cpuhold), 32'd1);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_error", 32'(out_error), 32'd0);
  endtask

  // One full load of wbuf[0..n-1]; bad corrupts the checksum byte when checksums exist
  task automatic run_load(input int n, input bit gaps, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    pulse_start();
    put(8'(n >> 8), gaps, 1'b0, 32'd0, 0);
    put(8'(n), gaps, 1'b0, 32'd0, 0);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(wbuf[i] >> (24 - 8 * k));
        cs ^= b;
        put(b, gaps, k == 3, wbuf[i], i);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    put(bad ? ~cs : cs, gaps, 1'b0, 32'd0, 0);
    chk("end_done", 32'(out_done), bad ? 32'd0 : 32'd1);
    chk("end_error", 32'(out_error), bad ? 32'd1 : 32'd0);
    chk("end_hold", 32'(out_ctrl_cpuhold), bad ? 32'd1 : 32'd0);
`else
    if (n > 0) begin
      chk("done_early", 32'(out_done), 32'd0);
      @(negedge clk);
    end
    chk("end_done", 32'(out_done), 32'd1);
    chk("end_error", 32'(out_error), 32'd0);
    chk("end_hold", 32'(out_ctrl_cpuhold), 32'd0);
    if (bad) $display("note: checksum corruption ignored without checksum support");
`endif
    chk("end_ready", 32'(bus.out_ready), 32'd0);
    chk("q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);

    // directed stream, back-to-back then with gaps
    wbuf = '{32'h12345678, 32'h9ABCDEF0};
    run_load(2, 1'b0, 1'b0);
    run_load(2, 1'b1, 1'b0);

    // reset with half a word in flight: no strobe may follow
    pulse_start();
    put(8'h00, 1'b0, 1'b0, 32'd0, 0);
    put(8'h01, 1'b0, 1'b0, 32'd0, 0);
    put(8'hAA, 1'b0, 1'b0, 32'd0, 0);
    put(8'hBB, 1'b0, 1'b0, 32'd0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // zero-length load
    wbuf.delete();
    run_load(0, 1'b0, 1'b0);

    // more words than memory depth: addresses wrap
    wbuf.delete();
    for (int i = 1; i <= 5; i++) wbuf.push_back(32'(i));
    run_load(5, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    wbuf = '{32'h01020304};
    run_load(1, 1'b0, 1'b0);
    run_load(1, 1'b0, 1'b1);
    run_load(1, 1'b0, 1'b0);
`endif

    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(0, 9);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back($urandom);
      bad = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`endif
      run_load(n, $urandom_range(0, 1) == 1, bad);
    end

    repeat (3) @(negedge clk);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
